ml_infer_seq: RTL and testbench

ML_INFER_SEQ -- requirements
Module: ml_infer_seq

---
 rtl/ml_seq_pkg.sv | 21 ++
 rtl/ml_settle_timer.sv | 31 +++
 rtl/ml_infer_seq.sv | 130 +++++++++++++
 tb/tb_ml_infer_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ml_seq_pkg.sv
// Shared types and defaults for the sequential inference front-end.
// Holds the FSM state encoding, default geometry and the statistics counter width.
package ml_seq_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam int DEF_WIDTH_A  = 4;
    localparam int DEF_NUM_A    = 21;
    localparam int DEF_OUTWIDTH = 2;
    localparam int CNT_W        = 16;

    // Saturating increment: a counter parked at all-ones stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ml_settle_timer.sv
// Settle countdown: after a start pulse, done is high on the SETTLE_CYC-th cycle.
// Idle (count 0) until the next start.
module ml_settle_timer #(
    parameter int SETTLE_CYC = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    localparam logic [7:0] TERM = 8'(SETTLE_CYC);

    logic [7:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= 8'd1;
        end else if (cnt == TERM) begin
            cnt <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign done = (cnt == TERM);

endmodule

// File: rtl/ml_infer_seq.sv
// Feature loader / classifier sequencer: LOAD -> SETTLE -> RESULT -> LOAD.
// Optional per-class result counters are enabled with the ML_CLASS_CNT_EN macro.
module ml_infer_seq
    import ml_seq_pkg::*;
#(
    parameter int WIDTH_A    = DEF_WIDTH_A,
    parameter int NUM_A      = DEF_NUM_A,
    parameter int OUTWIDTH   = DEF_OUTWIDTH,
    parameter int SETTLE_CYC = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH_A-1:0]         s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       s_last,
    output logic [NUM_A*WIDTH_A-1:0]   clf_inp,
    input  logic [OUTWIDTH-1:0]        clf_out,
    output logic [OUTWIDTH-1:0]        m_class,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       busy,
`ifdef ML_CLASS_CNT_EN
    output logic [(2**OUTWIDTH)*CNT_W-1:0] class_cnt,
`endif
    output logic                       err_len
);

    localparam int              IDX_W    = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_A - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             start;
    logic             done;
    logic             accept;

    assign accept = s_valid && s_ready;

    ml_settle_timer #(
        .SETTLE_CYC(SETTLE_CYC)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .done (done)
    );

    // The timer is kicked one cycle after SETTLE entry, so the first result
    // appears SETTLE_CYC+1 edges after the final feature is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD;
            idx     <= '0;
            start   <= 1'b0;
            clf_inp <= '0;
            m_class <= '0;
            m_valid <= 1'b0;
            err_len <= 1'b0;
            busy    <= 1'b0;
            s_ready <= 1'b0;
        end else begin
            err_len <= 1'b0;
            start   <= 1'b0;
            case (state)
                LOAD: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        for (int k = 0; k < NUM_A; k++) begin
                            if (idx == IDX_W'(k)) clf_inp[k*WIDTH_A +: WIDTH_A] <= s_data;
                        end
                        if (idx == LAST_IDX && s_last) begin
                            state   <= SETTLE;
                            idx     <= '0;
                            start   <= 1'b1;
                            s_ready <= 1'b0;
                            busy    <= 1'b1;
                        end else if (idx == LAST_IDX || s_last) begin
                            err_len <= 1'b1;
                            idx     <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (done) begin
                        m_class <= clf_out;
                        m_valid <= 1'b1;
                        state   <= RESULT;
                    end
                end
                RESULT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        busy    <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

`ifdef ML_CLASS_CNT_EN
    logic             hs;
    logic [CNT_W-1:0] cnt_q [2**OUTWIDTH];

    assign hs = (state == RESULT) && m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2**OUTWIDTH; c++) cnt_q[c] <= '0;
        end else if (hs) begin
            for (int c = 0; c < 2**OUTWIDTH; c++) begin
                if (m_class == OUTWIDTH'(c)) cnt_q[c] <= sat_inc(cnt_q[c]);
            end
        end
    end

    always_comb begin
        class_cnt = '0;
        for (int c = 0; c < 2**OUTWIDTH; c++) class_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
    end
`else
    // No per-class statistics in this build.
`endif

endmodule

// File: tb/tb_ml_infer_seq.sv
// Directed self-checking bench for ml_infer_seq with default parameters.
// Define ML_CLASS_CNT_EN at compile time to also check the per-class counters.
module tb_ml_infer_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_last = 1'b0;
    logic [83:0] clf_inp;
    logic [1:0]  clf_out = '0;
    logic [1:0]  m_class;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        busy;
    logic        err_len;
`ifdef ML_CLASS_CNT_EN
    logic [63:0] class_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ml_infer_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_last   (s_last),
        .clf_inp  (clf_inp),
        .clf_out  (clf_out),
        .m_class  (m_class),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .busy     (busy),
`ifdef ML_CLASS_CNT_EN
        .class_cnt(class_cnt),
`endif
        .err_len  (err_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_feature(input logic [3:0] d, input logic last);
        logic acc;
        acc     = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = s_ready;
            step();
        end
        if (!acc) check("accept_timeout", 0, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int last_at, input int base);
        for (int k = 0; k < n; k++) send_feature(4'(base + k), k == last_at);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!m_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic no_valid_for(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (m_valid) seen++;
            step();
        end
        check(tag, seen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        logic [1:0] cls [3];
        cls = '{2'd0, 2'd3, 2'd1};

        // Reset values
        #12;
        check("rst_clf_inp", clf_inp, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err_len", err_len, 0);
        check("rst_m_class", m_class, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("rst_s_ready", s_ready, 1);

        // Nominal frame: features 1..21, classifier says 2
        clf_out = 2'd2;
        send_frame(21, 20, 1);
        check("f1_busy", busy, 1);
        check("f1_s_ready", s_ready, 0);
        check("f1_feat0", clf_inp[3:0], 4'd1);
        check("f1_feat10", clf_inp[43:40], 4'd11);
        check("f1_feat20", clf_inp[83:80], 4'd5);
        wait_valid(lat);
        check("f1_latency", lat, 9);
        check("f1_class", m_class, 2);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("f1_valid_drop", m_valid, 0);
        check("f1_ready_back", s_ready, 1);
        check("f1_busy_drop", busy, 0);

        // Early s_last on feature 10
        clf_out = 2'd1;
        send_frame(10, 9, 1);
        check("early_err", err_len, 1);
        check("early_feat9", clf_inp[39:36], 4'd10);
        check("early_keep20", clf_inp[83:80], 4'd5);
        check("early_busy", busy, 0);
        step();
        check("early_err_pulse", err_len, 0);
        no_valid_for("early_no_valid", 20);

        // Clean frame after the error
        send_frame(21, 20, 3);
        check("f2_feat0", clf_inp[3:0], 4'd3);
        check("f2_feat20", clf_inp[83:80], 4'd7);
        wait_valid(lat);
        check("f2_latency", lat, 9);
        check("f2_class", m_class, 1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;

        // Missing s_last at the final index, then index restarts at 0
        send_frame(21, -1, 0);
        check("nolast_err", err_len, 1);
        check("nolast_busy", busy, 0);
        send_feature(4'hC, 1'b0);
        check("nolast_idx0", clf_inp[3:0], 4'hC);
        check("nolast_err_pulse", err_len, 0);
        send_feature(4'h0, 1'b1);
        check("resync_err", err_len, 1);

        // Result held while m_ready stays low
        clf_out = 2'd3;
        send_frame(21, 20, 2);
        wait_valid(lat);
        check("hold_latency", lat, 9);
        clf_out = 2'd0;
        s_valid = 1'b1;
        s_data  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", m_valid, 1);
            check("hold_class", m_class, 3);
            check("hold_s_ready", s_ready, 0);
            step();
        end
        s_valid = 1'b0;
        check("hold_ignored", clf_inp[3:0], 4'd2);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("hold_release", m_valid, 0);

        // Reset in the third SETTLE cycle
        clf_out = 2'd2;
        send_frame(21, 20, 4);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_clf_inp", clf_inp, 0);
        check("mid_rst_class", m_class, 0);
        check("mid_rst_err", err_len, 0);
        step();
        step();
        rst_n = 1'b1;
        no_valid_for("mid_rst_no_valid", 20);
        check("mid_rst_s_ready", s_ready, 1);
        clf_out = 2'd1;
        send_frame(21, 20, 5);
        wait_valid(lat);
        check("post_rst_latency", lat, 9);
        check("post_rst_class", m_class, 1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;

        // Back-to-back frames with m_ready tied high, from a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        m_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            clf_out = cls[f];
            send_frame(21, 20, f);
            wait_valid(lat);
            check("b2b_latency", lat, 9);
            check("b2b_class", m_class, cls[f]);
            step();
            check("b2b_one_cycle", m_valid, 0);
            check("b2b_s_ready", s_ready, 1);
        end
        m_ready = 1'b0;
`ifdef ML_CLASS_CNT_EN
        check("cnt_class0", class_cnt[15:0], 1);
        check("cnt_class1", class_cnt[31:16], 1);
        check("cnt_class2", class_cnt[47:32], 0);
        check("cnt_class3", class_cnt[63:48], 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
